// File: rtl/uart_bus_bridge_pkg.sv
// UART_pkg: shared types and byte constants for the UART-to-bus debug bridge.
//   bridge_state_t : bridge FSM states
//   CMD_* / RSP_*  : frame command bytes and response codes
//   is_cmd()       : true for a recognised command byte
package UART_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP,
        ERR
    } bridge_state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_bus_bridge_tx_seq.sv
// bridge_tx_seq: response serializer for the bridge.
// Loads either one byte (i_data[7:0]) or four bytes (i_data, MSB first) and
// hands them to the UART transmitter one at a time.
//   clk, rst     : clock, synchronous active-low reset
//   i_load       : load a new response (only while idle)
//   i_four       : 1 = four-byte response, 0 = single byte
//   i_data       : response payload
//   i_tx_ready   : transmitter can take a byte
//   o_tx_byte    : byte currently offered
//   o_tx_start   : one-cycle transmit pulse
//   o_done       : high with the tx_start of the final byte
module bridge_tx_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_four,
    input  logic [31:0] i_data,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [2:0]  r_left;
    logic        r_gap;
    logic        w_fire;

    // r_gap forces one dead cycle after every tx_start so the transmitter
    // has time to drop tx_ready before we look at it again.
    assign w_fire     = (r_left != 3'd0) && !r_gap && i_tx_ready;
    assign o_tx_start = w_fire;
    assign o_tx_byte  = r_shift[31:24];
    assign o_done     = w_fire && (r_left == 3'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_left  <= '0;
            r_gap   <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_four ? i_data : {i_data[7:0], 24'h0};
            r_left  <= i_four ? 3'd4 : 3'd1;
            r_gap   <= 1'b0;
        end else begin
            r_gap <= w_fire;
            if (w_fire) begin
                r_shift <= {r_shift[23:0], 8'h00};
                r_left  <= r_left - 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses UART command frames and performs single-word
// reads/writes on the memory-map bus, returning ACK/NAK or read data.
//   clk, rst            : clock, synchronous active-low reset
//   rx_byte, rx_valid   : byte stream from the UART receiver
//   tx_ready            : transmitter can accept a byte
//   tx_byte, tx_start   : byte stream to the UART transmitter
//   MemData             : bus read data (combinational in the MemRead cycle)
//   MemRead, MemWrite   : one-cycle bus strobes
//   RWAddress, WriteData: bus address / write data (held between frames)
//   halt_core           : bridge owns the bus for the current frame
//   overrun             : sticky, a byte arrived while the bridge was busy
module uart_bus_bridge
    import UART_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] RWAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  halt_core,
    output logic                  overrun
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // r_to equals the number of cycles since the last accepted byte, so
    // deciding at TIMEOUT_CYCLES-1 puts the NAK exactly TIMEOUT_CYCLES
    // cycles after that byte.
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t         r_state, w_next;
    logic                  r_is_wr;
    logic [1:0]            r_byte_cnt;
    logic [TO_W-1:0]       r_to;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_overrun;

    logic        w_collect, w_last, w_timeout, w_misalign;
    logic        w_load, w_load_four, w_seq_done;
    logic [31:0] w_load_data;

    assign w_collect  = (r_state == ADDR) || (r_state == DATA);
    assign w_last     = rx_valid && (r_byte_cnt == 2'd3);
    assign w_timeout  = w_collect && !rx_valid && (r_to >= TO_LIM);
    // Only meaningful on the final address byte, which carries A[1:0].
    assign w_misalign = (rx_byte[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (rx_valid) w_next = is_cmd(rx_byte) ? ADDR : ERR;
            ADDR: begin
                if (w_last)         w_next = w_misalign ? ERR : (r_is_wr ? DATA : BUS);
                else if (w_timeout) w_next = ERR;
            end
            DATA: begin
                if (w_last)         w_next = BUS;
                else if (w_timeout) w_next = ERR;
            end
            BUS:       w_next = RESP;
            RESP, ERR: if (w_seq_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        halt_core   = (r_state != IDLE);
        w_load      = 1'b0;
        w_load_four = 1'b0;
        w_load_data = {24'h0, RSP_NAK};
        if (r_state == BUS) begin
            MemWrite    = r_is_wr;
            MemRead     = !r_is_wr;
            // Read data is sampled into the serializer at the end of BUS.
            w_load      = 1'b1;
            w_load_four = !r_is_wr;
            w_load_data = r_is_wr ? {24'h0, RSP_ACK} : MemData;
        end
        // Any path into ERR queues a single NAK.
        if ((w_next == ERR) && (r_state != ERR)) w_load = 1'b1;
    end

    // Frame assembly, timeout and overrun tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_wr    <= 1'b0;
            r_byte_cnt <= '0;
            r_to       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (rx_valid && (r_state == IDLE)) r_is_wr <= (rx_byte == CMD_WR);
            if (rx_valid && (r_state == ADDR)) r_addr  <= {r_addr[ADDR_WIDTH-9:0], rx_byte};
            if (rx_valid && (r_state == DATA)) r_wdata <= {r_wdata[DATA_WIDTH-9:0], rx_byte};

            // 2-bit counter wraps to 0 after the 4th byte, ready for DATA.
            if (!w_collect)    r_byte_cnt <= '0;
            else if (rx_valid) r_byte_cnt <= r_byte_cnt + 2'd1;

            if (rx_valid)       r_to <= TO_W'(1);
            else if (w_collect) r_to <= r_to + TO_W'(1);
            else                r_to <= '0;

            if (rx_valid && ((r_state == BUS) || (r_state == RESP) || (r_state == ERR)))
                r_overrun <= 1'b1;
        end
    end

    assign RWAddress = r_addr;
    assign WriteData = r_wdata;
    assign overrun   = r_overrun;

    bridge_tx_seq u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_four     (w_load_four),
        .i_data     (w_load_data),
        .i_tx_ready (tx_ready),
        .o_tx_byte  (tx_byte),
        .o_tx_start (tx_start),
        .o_done     (w_seq_done)
    );

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] MemData = 32'h0;
    logic [7:0]  tx_byte;
    logic        tx_start, MemRead, MemWrite, halt_core, overrun;
    logic [31:0] RWAddress, WriteData;

    always #5 clk = ~clk;

    uart_bus_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_start(tx_start),
        .MemData(MemData), .MemRead(MemRead), .MemWrite(MemWrite),
        .RWAddress(RWAddress), .WriteData(WriteData),
        .halt_core(halt_core), .overrun(overrun)
    );

    typedef struct packed {
        logic        is_wr;
        logic        both;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave memory and the model's own view of memory.
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    // Environment: transmitter readiness and combinational-looking read data.
    bit ready_rand = 1'b0;
    bit ready_hold = 1'b1;
    always @(posedge clk) begin
        #1;
        tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_hold;
        MemData  = slv_rd(RWAddress);
    end

    // Monitor: record everything the DUT emits.
    logic [7:0]  tx_seen [$];
    int unsigned tx_cyc  [$];
    logic        tx_rdy  [$];
    op_t         ops     [$];
    always @(negedge clk) begin
        op_t op;
        if (tx_start) begin
            tx_seen.push_back(tx_byte);
            tx_cyc.push_back(cyc);
            tx_rdy.push_back(tx_ready);
        end
        if (MemRead || MemWrite) begin
            op.is_wr = MemWrite;
            op.both  = MemRead && MemWrite;
            op.addr  = RWAddress;
            op.data  = MemWrite ? WriteData : 32'h0;
            ops.push_back(op);
            if (MemWrite) slv_mem[RWAddress] = WriteData;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int unsigned last_rx;
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        last_rx  = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    // Reference model: what a frame should produce, from the frame rules.
    logic [7:0] exp_tx  [$];
    op_t        exp_ops [$];
    task automatic model(input logic [7:0] fr[$]);
        logic [31:0] a, d;
        op_t op;
        exp_tx.delete();
        exp_ops.delete();
        if (fr[0] != 8'h57 && fr[0] != 8'h52) begin
            exp_tx.push_back(8'h15);
            return;
        end
        a = {fr[1], fr[2], fr[3], fr[4]};
        if (a % 4 != 0) begin
            exp_tx.push_back(8'h15);
            return;
        end
        op.both = 1'b0;
        op.addr = a;
        if (fr[0] == 8'h57) begin
            d = {fr[5], fr[6], fr[7], fr[8]};
            op.is_wr = 1'b1;
            op.data  = d;
            mdl_mem[a] = d;
            exp_tx.push_back(8'h06);
        end else begin
            d = mdl_rd(a);
            op.is_wr = 1'b0;
            op.data  = 32'h0;
            for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((d >> (8 * i)) & 32'hFF));
        end
        exp_ops.push_back(op);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (halt_core && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_halt_low"}, halt_core, 0);
    endtask

    task automatic check_frame(input string tag, input int t0, input int o0);
        chk({tag, "_ntx"}, tx_seen.size() - t0, exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (t0 + i < tx_seen.size()) begin
                chk({tag, "_txbyte"}, tx_seen[t0 + i], exp_tx[i]);
                chk({tag, "_txready"}, tx_rdy[t0 + i], 1);
                if (t0 + i > 0)
                    chk({tag, "_txgap"}, (tx_cyc[t0 + i] - tx_cyc[t0 + i - 1]) >= 2, 1);
            end
        end
        chk({tag, "_nops"}, ops.size() - o0, exp_ops.size());
        for (int i = 0; i < exp_ops.size(); i++) begin
            if (o0 + i < ops.size()) begin
                chk({tag, "_op_wr"}, ops[o0 + i].is_wr, exp_ops[i].is_wr);
                chk({tag, "_op_both"}, ops[o0 + i].both, 0);
                chk({tag, "_op_addr"}, ops[o0 + i].addr, exp_ops[i].addr);
                if (exp_ops[i].is_wr) chk({tag, "_op_data"}, ops[o0 + i].data, exp_ops[i].data);
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fr[$], input int maxgap);
        int t0 = tx_seen.size();
        int o0 = ops.size();
        model(fr);
        foreach (fr[i]) begin
            send(fr[i]);
            if (i == 0) chk({tag, "_halt_rise"}, halt_core, 1);
            if (i != fr.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
        end
        wait_idle(tag);
        check_frame(tag, t0, o0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_MemRead"}, MemRead, 0);
        chk({tag, "_MemWrite"}, MemWrite, 0);
        chk({tag, "_RWAddress"}, RWAddress, 0);
        chk({tag, "_WriteData"}, WriteData, 0);
        chk({tag, "_tx_byte"}, tx_byte, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_halt_core"}, halt_core, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [7:0]  fr [$];
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  b;
        int t0, o0, r;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst_in");
        rst = 1'b1;
        tick();
        chk_reset_outputs("rst_out");

        // Directed write, latency with tx_ready held high
        t0 = tx_seen.size();
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("wr10", fr, 0);
        if (tx_cyc.size() > t0) chk("wr10_latency", tx_cyc[t0] - last_rx, 2);
        chk("wr10_hold_addr", RWAddress, 32'h10);
        chk("wr10_hold_data", WriteData, 32'hDEADBEEF);

        // Directed read
        slv_mem[32'h10] = 32'h12345678;
        mdl_mem[32'h10] = 32'h12345678;
        t0 = tx_seen.size();
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        run_frame("rd10", fr, 0);
        if (tx_cyc.size() > t0) chk("rd10_latency", tx_cyc[t0] - last_rx, 2);

        // Bad command, misaligned write
        fr = '{8'h41};
        run_frame("badcmd", fr, 0);
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h13};
        run_frame("misalign", fr, 0);

        // Timeout after a partial write frame
        t0 = tx_seen.size();
        o0 = ops.size();
        send(8'h57);
        send(8'h00);
        send(8'h00);
        wait_idle("timeout");
        chk("timeout_ntx", tx_seen.size() - t0, 1);
        if (tx_seen.size() > t0) begin
            chk("timeout_nak", tx_seen[t0], 8'h15);
            chk("timeout_cycle", tx_cyc[t0] - last_rx, TO);
        end
        chk("timeout_nops", ops.size() - o0, 0);
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        run_frame("after_to", fr, 0);

        // Randomized frames with random tx_ready and inter-byte gaps
        ready_rand = 1'b1;
        for (int k = 0; k < 24; k++) begin
            fr.delete();
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h10;
                3: a = 32'h20;
                4: a = 32'h100;
                default: a = $urandom & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 99) < 15) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            if (r < 12) begin
                do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
                fr.push_back(b);
            end else begin
                fr.push_back(r < 56 ? 8'h57 : 8'h52);
                for (int i = 3; i >= 0; i--) fr.push_back(8'((a >> (8 * i)) & 32'hFF));
                if (r < 56 && a % 4 == 0)
                    for (int i = 3; i >= 0; i--) fr.push_back(8'((d >> (8 * i)) & 32'hFF));
            end
            run_frame("rand", fr, 4);
        end
        ready_rand = 1'b0;
        ready_hold = 1'b1;
        tick();
        chk("overrun_clear", overrun, 0);

        // Stalled transmitter during a read response, plus an overrun byte
        ready_hold = 1'b0;
        repeat (2) tick();
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        model(fr);
        t0 = tx_seen.size();
        o0 = ops.size();
        foreach (fr[i]) send(fr[i]);
        repeat (50) tick();
        chk("stall_no_tx", tx_seen.size() - t0, 0);
        chk("stall_tx_start", tx_start, 0);
        chk("stall_halt", halt_core, 1);
        send(8'hAA);
        chk("stall_overrun", overrun, 1);
        ready_hold = 1'b1;
        wait_idle("stall");
        check_frame("stall", t0, o0);
        chk("overrun_sticky", overrun, 1);

        // Reset in the middle of a write frame
        t0 = tx_seen.size();
        o0 = ops.size();
        send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h20); send(8'h11);
        rst = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_nops", ops.size() - o0, 0);
        chk("midrst_ntx", tx_seen.size() - t0, 0);
        chk_reset_outputs("midrst_after");
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("post_rst_wr", fr, 2);
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
        run_frame("post_rst_rd", fr, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
